// File: rtl/draw_rect_gen.sv
// Rectangle rasteriser: walks a filled or outline rectangle in raster order and
// emits one pixel per plot/plot_ready handshake, skipping off-screen pixels.
module draw_rect_gen #(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     start_x,
  input  logic [Y_W-1:0]     start_y,
  input  logic [X_W-1:0]     width,
  input  logic [Y_W-1:0]     height,
  input  logic [COLOR_W-1:0] color,
  input  logic               mode,
  input  logic               plot_ready,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color_out,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  state_e             r_state;
  logic [X_W-1:0]     r_sx, r_w, r_cx;
  logic [Y_W-1:0]     r_sy, r_h, r_cy;
  logic               r_mode;
  logic [X_W-1:0]     r_x_out;
  logic [Y_W-1:0]     r_y_out;
  logic [COLOR_W-1:0] r_color_out;
  logic               r_plot, r_busy, r_done;

  logic               w_adv, w_row_end, w_last_row, w_interior, w_vis, w_idle;
  logic [X_W-1:0]     w_ncx, w_bx, w_pcx;
  logic [Y_W-1:0]     w_ncy, w_by, w_pcy;
  logic [X_W:0]       w_sum_x;
  logic [Y_W:0]       w_sum_y;

  // Clipped pixels (plot low) retire without waiting for the sink.
  assign w_adv      = (r_state == StDraw) && (!r_plot || plot_ready);
  assign w_row_end  = (r_cx == r_w - X_W'(1));
  assign w_last_row = (r_cy == r_h - Y_W'(1));
  assign w_interior = r_mode && (r_cy != '0) && !w_last_row;

  always_comb begin
    w_ncx = r_cx;
    w_ncy = r_cy;
    if (w_row_end) begin
      w_ncx = '0;
      w_ncy = r_cy + Y_W'(1);
    end else if (w_interior) begin
      w_ncx = r_w - X_W'(1);
    end else begin
      w_ncx = r_cx + X_W'(1);
    end
  end

  // The start cycle computes pixel (0,0) straight from the command inputs.
  assign w_idle  = (r_state == StIdle);
  assign w_bx    = w_idle ? start_x : r_sx;
  assign w_by    = w_idle ? start_y : r_sy;
  assign w_pcx   = w_idle ? '0 : w_ncx;
  assign w_pcy   = w_idle ? '0 : w_ncy;
  assign w_sum_x = {1'b0, w_bx} + {1'b0, w_pcx};
  assign w_sum_y = {1'b0, w_by} + {1'b0, w_pcy};
  assign w_vis   = (32'(w_sum_x) < SCREEN_W) && (32'(w_sum_y) < SCREEN_H);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_sx        <= '0;
      r_sy        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_mode      <= 1'b0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_color_out <= '0;
      r_plot      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_plot <= 1'b0;
          r_done <= 1'b0;
          if (start) begin
            r_sx   <= start_x;
            r_sy   <= start_y;
            r_w    <= width;
            r_h    <= height;
            r_mode <= mode;
            r_cx   <= '0;
            r_cy   <= '0;
            r_busy <= 1'b1;
            if (width == '0 || height == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state     <= StDraw;
              r_x_out     <= w_sum_x[X_W-1:0];
              r_y_out     <= w_sum_y[Y_W-1:0];
              r_color_out <= color;
              r_plot      <= w_vis;
            end
          end
        end
        StDraw: begin
          if (w_adv) begin
            if (w_row_end && w_last_row) begin
              r_state <= StDone;
              r_plot  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cx    <= w_ncx;
              r_cy    <= w_ncy;
              r_x_out <= w_sum_x[X_W-1:0];
              r_y_out <= w_sum_y[Y_W-1:0];
              r_plot  <= w_vis;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_plot  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign x_out     = r_x_out;
  assign y_out     = r_y_out;
  assign color_out = r_color_out;
  assign plot      = r_plot;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_draw_rect_gen.sv
// Directed bench for draw_rect_gen: drives commands on the falling edge and
// checks registered outputs on the falling edge against hand-computed values.
module tb_draw_rect_gen;

  logic       clk = 1'b0;
  logic       reset, start, mode, plot_ready;
  logic [7:0] start_x, start_y, width, height;
  logic [2:0] color;
  logic [7:0] x_out, y_out;
  logic [2:0] color_out;
  logic       plot, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  draw_rect_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_x    (start_x),
    .start_y    (start_y),
    .width      (width),
    .height     (height),
    .color      (color),
    .mode       (mode),
    .plot_ready (plot_ready),
    .x_out      (x_out),
    .y_out      (y_out),
    .color_out  (color_out),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  // Pulses start for one cycle; returns at the falling edge where pixel 0 shows.
  task automatic issue(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] w,
                       input logic [7:0] h, input logic [2:0] c, input logic m);
    @(negedge clk);
    start = 1'b1; start_x = sx; start_y = sy; width = w; height = h; color = c; mode = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({x_out, y_out, color_out, plot, busy, done} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_state: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b, want all 0",
               x_out, y_out, color_out, plot, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_filled();
    logic [7:0] ex, ey;
    plot_ready = 1'b1;
    issue(8'd10, 8'd20, 8'd3, 8'd2, 3'd5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ex = 8'(10 + i % 3);
      ey = 8'(20 + i / 3);
      n_tests++;
      if ({plot, busy, done, x_out, y_out, color_out} !== {3'b110, ex, ey, 3'd5}) begin
        n_fail++;
        $display("FAIL filled_px%0d: got plot=%b busy=%b done=%b (%0d,%0d) c=%0d, want 1 1 0 (%0d,%0d) c=5",
                 i, plot, busy, done, x_out, y_out, color_out, ex, ey);
      end
      @(negedge clk);
    end
    n_tests++;
    if ({plot, busy, done} !== 3'b011) begin
      n_fail++;
      $display("FAIL filled_done: got plot=%b busy=%b done=%b, want 0 1 1", plot, busy, done);
    end
    @(negedge clk);
    n_tests++;
    if ({plot, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL filled_idle: got plot=%b busy=%b done=%b, want 0 0 0", plot, busy, done);
    end
  endtask

  task automatic test_outline();
    logic [7:0] ox [10];
    logic [7:0] oy [10];
    ox = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
    oy = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2};
    plot_ready = 1'b1;
    issue(8'd0, 8'd0, 8'd4, 8'd3, 3'd2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ({plot, done, x_out, y_out} !== {2'b10, ox[i], oy[i]}) begin
        n_fail++;
        $display("FAIL outline_px%0d: got plot=%b done=%b (%0d,%0d), want plot=1 done=0 (%0d,%0d)",
                 i, plot, done, x_out, y_out, ox[i], oy[i]);
      end
      @(negedge clk);
    end
    n_tests++;
    if ({plot, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL outline_done: got plot=%b done=%b, want 0 1", plot, done);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL outline_single_done: got done=%b, want 0", done);
    end
  endtask

  // Stalls the first pixel while also waving a stray start with other geometry.
  task automatic test_backpressure();
    int accepted = 0;
    plot_ready = 1'b0;
    issue(8'd30, 8'd40, 8'd2, 8'd1, 3'd3, 1'b0);
    start = 1'b1; start_x = 8'd99; start_y = 8'd99; width = 8'd9; height = 8'd9;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({plot, x_out, y_out, color_out} !== {1'b1, 8'd30, 8'd40, 3'd3}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got plot=%b (%0d,%0d) c=%0d, want plot=1 (30,40) c=3",
                 i, plot, x_out, y_out, color_out);
      end
      if (i < 2) @(negedge clk);
    end
    start = 1'b0;
    plot_ready = 1'b1;
    if (plot && plot_ready) accepted++;
    @(negedge clk);
    n_tests++;
    if ({plot, x_out, y_out} !== {1'b1, 8'd31, 8'd40}) begin
      n_fail++;
      $display("FAIL bp_second: got plot=%b (%0d,%0d), want plot=1 (31,40)", plot, x_out, y_out);
    end
    if (plot && plot_ready) accepted++;
    @(negedge clk);
    if (plot && plot_ready) accepted++;
    n_tests++;
    if (accepted != 2 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_count: got accepted=%0d done=%b, want accepted=2 done=1", accepted, done);
    end
    @(negedge clk);
  endtask

  task automatic test_clip();
    logic [3:0] plots;
    plot_ready = 1'b1;
    issue(8'd158, 8'd5, 8'd4, 8'd1, 3'd1, 1'b0);
    n_tests++;
    if ({plot, x_out} !== {1'b1, 8'd158}) begin
      n_fail++;
      $display("FAIL clip_first: got plot=%b x=%0d, want plot=1 x=158", plot, x_out);
    end
    for (int i = 0; i < 4; i++) begin
      plots[i] = plot;
      @(negedge clk);
    end
    n_tests++;
    if (plots !== 4'b0011 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL clip_edge: got plots=%b done=%b, want plots=0011 done=1", plots, done);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int n_plot = 0;
    plot_ready = 1'b1;
    issue(8'd250, 8'd0, 8'd10, 8'd1, 3'd6, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (plot !== 1'b0 || done !== 1'b0) n_plot++;
      @(negedge clk);
    end
    n_tests++;
    if (n_plot != 0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL clip_wrap: got bad_cycles=%0d done=%b, want 0 and done=1", n_plot, done);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    issue(8'd7, 8'd7, 8'd0, 8'd3, 3'd4, 1'b0);
    n_tests++;
    if ({plot, busy, done} !== 3'b011) begin
      n_fail++;
      $display("FAIL zero_w: got plot=%b busy=%b done=%b, want 0 1 1", plot, busy, done);
    end
    @(negedge clk);
    issue(8'd7, 8'd7, 8'd3, 8'd0, 3'd4, 1'b0);
    n_tests++;
    if ({plot, busy, done} !== 3'b011) begin
      n_fail++;
      $display("FAIL zero_h: got plot=%b busy=%b done=%b, want 0 1 1", plot, busy, done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic saw_done = 1'b0;
    plot_ready = 1'b1;
    issue(8'd5, 8'd5, 8'd4, 8'd4, 3'd2, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({plot, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid: got plot=%b busy=%b done=%b, want 0 0 0", plot, busy, done);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: got done_seen=%b busy=%b, want 0 0", saw_done, busy);
    end
    issue(8'd1, 8'd2, 8'd1, 8'd1, 3'd7, 1'b0);
    n_tests++;
    if ({plot, x_out, y_out, color_out} !== {1'b1, 8'd1, 8'd2, 3'd7}) begin
      n_fail++;
      $display("FAIL reset_restart: got plot=%b (%0d,%0d) c=%0d, want plot=1 (1,2) c=7",
               plot, x_out, y_out, color_out);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_restart_done: got done=%b, want 1", done);
    end
    @(negedge clk);
  endtask

  // Start held through DONE must only be taken on the following IDLE cycle.
  task automatic test_back_to_back();
    plot_ready = 1'b1;
    issue(8'd50, 8'd60, 8'd1, 8'd1, 3'd1, 1'b0);
    @(negedge clk);
    start = 1'b1; start_x = 8'd70; start_y = 8'd80; width = 8'd1; height = 8'd1; color = 3'd2;
    n_tests++;
    if ({done, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_done: got done=%b busy=%b, want 1 1", done, busy);
    end
    @(negedge clk);
    n_tests++;
    if ({plot, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_idle: got plot=%b busy=%b done=%b, want 0 0 0", plot, busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({plot, busy, x_out, y_out, color_out} !== {2'b11, 8'd70, 8'd80, 3'd2}) begin
      n_fail++;
      $display("FAIL b2b_second: got plot=%b busy=%b (%0d,%0d) c=%0d, want 1 1 (70,80) c=2",
               plot, busy, x_out, y_out, color_out);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; plot_ready = 1'b1;
    start_x = '0; start_y = '0; width = '0; height = '0; color = '0;
    test_reset();
    test_filled();
    test_outline();
    test_backpressure();
    test_clip();
    test_overflow();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
